// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the four-way round-robin mux arbiter.
// The onehot helper turns a requester index into its grant bit.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_4.sv
// Plain four-input multiplexer shared by the arbiter's requesters.
module mux_4 #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_d0,
  input  logic [W-1:0] i_d1,
  input  logic [W-1:0] i_d2,
  input  logic [W-1:0] i_d3,
  input  logic [1:0]   i_sel,
  output logic [W-1:0] o_y
);

  always_comb begin
    o_y = i_d0;
    case (i_sel)
      2'd0:    o_y = i_d0;
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      default: o_y = i_d3;
    endcase
  end

endmodule

// File: rtl/rr_pick_4.sv
// Combinational round-robin picker: first set bit of req searching from
// last+1 upward, wrapping around, with last itself considered lowest priority.
module rr_pick_4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = last;
    cand  = last;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = last + SEL_W'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_4_arbiter.sv
// Round-robin arbiter sharing one mux_4 between four requesters, with a
// registered one-hot grant and an optional hold limit against starvation.
module mux_4_arbiter
  import mux_arb_pkg::*;
#(
  parameter int W        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic [W-1:0]     i_data0,
  input  logic [W-1:0]     i_data1,
  input  logic [W-1:0]     i_data2,
  input  logic [W-1:0]     i_data3,
  output logic [N_REQ-1:0] o_gnt,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_busy,
  output logic [W-1:0]     o_data
);

  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             idle_found, other_found;
  logic [SEL_W-1:0] idle_idx, other_idx;
  logic [N_REQ-1:0] req_other;
  logic             hold_hit;

  // In GRANT, last equals the grantee, so masking it and searching from it
  // serves both the release hand-off and the preemption pick.
  assign req_other = i_req & ~onehot(last_q);

  rr_pick_4 u_pick_idle (
    .req   (i_req),
    .last  (last_q),
    .found (idle_found),
    .idx   (idle_idx)
  );

  rr_pick_4 u_pick_other (
    .req   (req_other),
    .last  (last_q),
    .found (other_found),
    .idx   (other_idx)
  );

  // Counter is 0 in the first grant cycle, so the limit is hit one below MAX_HOLD.
  assign hold_hit = (MAX_HOLD != 0) && ((cnt_q == HOLD_LAST) || (cnt_q == CNT_MAX));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (idle_found) begin
          state_d = GRANT;
          gnt_d   = onehot(idle_idx);
          sel_d   = idle_idx;
          last_d  = idle_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!i_req[sel_q] || (hold_hit && other_found)) begin
          if (other_found) begin
            gnt_d  = onehot(other_idx);
            sel_d  = other_idx;
            last_d = other_idx;
            cnt_d  = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= SEL_W'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_gnt  = gnt_q;
  assign o_sel  = sel_q;
  assign o_busy = |gnt_q;

  mux_4 #(.W(W)) u_mux (
    .i_d0  (i_data0),
    .i_d1  (i_data1),
    .i_d2  (i_data2),
    .i_d3  (i_data3),
    .i_sel (sel_q),
    .o_y   (o_data)
  );

endmodule

// File: tb/tb_mux_4_arbiter.sv
// Directed bench for mux_4_arbiter: one instance with the default hold limit
// and one with MAX_HOLD = 0, checked at falling edges against fixed vectors.
module tb_mux_4_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] req_u;
  logic [3:0] data0, data1, data2, data3;
  logic [3:0] gnt, gnt_u;
  logic [1:0] sel, sel_u;
  logic       busy, busy_u;
  logic [3:0] dout, dout_u;

  int n_cmp;
  int n_fail;

  mux_4_arbiter #(.W(4), .MAX_HOLD(8)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_req   (req),
    .i_data0 (data0),
    .i_data1 (data1),
    .i_data2 (data2),
    .i_data3 (data3),
    .o_gnt   (gnt),
    .o_sel   (sel),
    .o_busy  (busy),
    .o_data  (dout)
  );

  mux_4_arbiter #(.W(4), .MAX_HOLD(0)) dut_u (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_req   (req_u),
    .i_data0 (data0),
    .i_data1 (data1),
    .i_data2 (data2),
    .i_data3 (data3),
    .o_gnt   (gnt_u),
    .o_sel   (sel_u),
    .o_busy  (busy_u),
    .o_data  (dout_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd0) begin
        n_fail++;
        $display("[TB] FAIL reset_idle cycle %0d: gnt=%b busy=%b sel=%0d, want 0000/0/0", c, gnt, busy, sel);
      end
      n_cmp++;
      if (dout !== data0) begin
        n_fail++;
        $display("[TB] FAIL reset_data: got %h want %h", dout, data0);
      end
      tick();
    end
  endtask

  task automatic test_rotation();
    logic [1:0] order [5];
    logic [3:0] exp_d [4];
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_d = '{4'h0, 4'h5, 4'hA, 4'hF};
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 8; c++) begin
        n_cmp++;
        if (gnt !== (4'b0001 << order[k]) || sel !== order[k] || dout !== exp_d[order[k]]) begin
          n_fail++;
          $display("[TB] FAIL rotation slot %0d cycle %0d: gnt=%b sel=%0d data=%h, want sel=%0d data=%h",
                   k, c, gnt, sel, dout, order[k], exp_d[order[k]]);
        end
        tick();
      end
    end
    // Requester 1 has just taken over; dropping everything must idle with sel kept.
    req = 4'b0000;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd1) begin
      n_fail++;
      $display("[TB] FAIL idle_keeps_sel: gnt=%b busy=%b sel=%0d, want 0000/0/1", gnt, busy, sel);
    end
  endtask

  task automatic test_single_hold();
    req = 4'b0100;
    tick();
    for (int c = 0; c < 20; c++) begin
      n_cmp++;
      if (gnt !== 4'b0100 || sel !== 2'd2 || busy !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL single_hold cycle %0d: gnt=%b sel=%0d busy=%b, want 0100/2/1", c, gnt, sel, busy);
      end
      tick();
    end
    req = 4'b0000;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL single_release: gnt=%b want 0000", gnt);
    end
  endtask

  task automatic test_back_to_back();
    req = 4'b0010;
    tick();
    n_cmp++;
    if (gnt !== 4'b0010 || sel !== 2'd1) begin
      n_fail++;
      $display("[TB] FAIL b2b_first: gnt=%b sel=%0d, want 0010/1", gnt, sel);
    end
    req = 4'b1000;
    tick();
    n_cmp++;
    if (gnt !== 4'b1000 || sel !== 2'd3 || busy !== 1'b1 || dout !== 4'hF) begin
      n_fail++;
      $display("[TB] FAIL b2b_handoff: gnt=%b sel=%0d busy=%b data=%h, want 1000/3/1/f", gnt, sel, busy, dout);
    end
  endtask

  task automatic test_after_three();
    req = 4'b0000;
    tick();
    req = 4'b1001;
    tick();
    for (int c = 0; c < 8; c++) begin
      n_cmp++;
      if (gnt !== 4'b0001 || sel !== 2'd0) begin
        n_fail++;
        $display("[TB] FAIL after_three cycle %0d: gnt=%b sel=%0d, want 0001/0", c, gnt, sel);
      end
      tick();
    end
    n_cmp++;
    if (gnt !== 4'b1000 || sel !== 2'd3) begin
      n_fail++;
      $display("[TB] FAIL after_three_preempt: gnt=%b sel=%0d, want 1000/3", gnt, sel);
    end
  endtask

  task automatic test_unlimited();
    req_u = 4'b0011;
    tick();
    for (int c = 0; c < 30; c++) begin
      n_cmp++;
      if (gnt_u !== 4'b0001 || sel_u !== 2'd0 || busy_u !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL unlimited_hold cycle %0d: gnt=%b sel=%0d busy=%b, want 0001/0/1", c, gnt_u, sel_u, busy_u);
      end
      tick();
    end
    req_u = 4'b0010;
    tick();
    n_cmp++;
    if (gnt_u !== 4'b0010 || sel_u !== 2'd1 || dout_u !== 4'h5) begin
      n_fail++;
      $display("[TB] FAIL unlimited_handoff: gnt=%b sel=%0d data=%h, want 0010/1/5", gnt_u, sel_u, dout_u);
    end
    req_u = 4'b0000;
    tick();
    n_cmp++;
    if (gnt_u !== 4'b0000 || busy_u !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL unlimited_release: gnt=%b busy=%b, want 0000/0", gnt_u, busy_u);
    end
  endtask

  task automatic test_async_reset();
    req = 4'b0100;
    tick();
    n_cmp++;
    if (gnt !== 4'b0100 || sel !== 2'd2) begin
      n_fail++;
      $display("[TB] FAIL areset_pre: gnt=%b sel=%0d, want 0100/2", gnt, sel);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd0 || dout !== data0) begin
      n_fail++;
      $display("[TB] FAIL areset_immediate: gnt=%b busy=%b sel=%0d data=%h, want 0000/0/0/%h",
               gnt, busy, sel, dout, data0);
    end
    @(negedge clk);
    req = 4'b0110;
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (gnt !== 4'b0010 || sel !== 2'd1) begin
      n_fail++;
      $display("[TB] FAIL areset_rearb: gnt=%b sel=%0d, want 0010/1", gnt, sel);
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    req    = 4'b0000;
    req_u  = 4'b0000;
    data0  = 4'h0;
    data1  = 4'h5;
    data2  = 4'hA;
    data3  = 4'hF;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    test_reset();
    test_rotation();
    test_single_hold();
    test_back_to_back();
    test_after_three();
    test_unlimited();
    test_async_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_4_arbiter.md
# mux_4_arbiter

Round-robin arbiter that shares one `mux_4` datapath between four requesters. Each requester holds `i_req[k]` for the length of its transaction. The arbiter issues a registered one-hot grant and drives the `mux_4` select so the granted requester's data reaches `o_data`. An optional hold limit stops any single requester from starving the others.

## Interface
- `W`, 4: data width of each input and of `o_data`.
- `MAX_HOLD`, 8: maximum consecutive grant cycles while another requester is pending. 0 means unlimited.
- `i_clk` input 1: clock; all state updates on the rising edge.
- `i_rst` input 1: reset, asynchronous, active-high.
- `i_req` input 4: request vector; bit k belongs to requester k.
- `i_data0`..`i_data3` input W each: requester data, forwarded through `mux_4`.
- `o_gnt` output 4: registered grant, one-hot or all-zero.
- `o_sel` output 2: registered `mux_4` select; equals the index of the granted requester.
- `o_busy` output 1: high iff `o_gnt != 0`.
- `o_data` output W: output of the internal `mux_4` instance, driven from `o_sel`; combinational from `o_sel` and the data inputs.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: one requester owns the mux.
- Round-robin pointer `last` (2 bit):
  - Holds the index of the most recent grantee.
  - Search order is `last+1`, `last+2`, `last+3`, `last`, all mod 4.
- IDLE:
  - If `i_req != 0`: grant the first requesting index in search order, go to GRANT, set `last` to that index, clear the hold counter.
  - Else stay in IDLE.
- GRANT, with current grantee g:
  - Release: `i_req[g]` low at the edge.
    - Pick the next grantee from `i_req` with bit g masked.
    - If one is found: switch directly to it with no bubble cycle, and clear the counter.
    - Else: go to IDLE.
  - Preemption: `MAX_HOLD != 0`, counter reaches `MAX_HOLD`, and some `i_req[k]` with k≠g is high.
    - Grant the next requester in search order excluding g.
    - g must re-arbitrate and is now last in order.
  - Counter reaches `MAX_HOLD` with no other request pending: keep the grant and saturate the counter. Preemption happens on the first edge another request appears.
  - Otherwise: keep the grant and increment the counter.
- Requests arriving while another requester holds the grant are only acted on at release or preemption; the current grant is never interrupted otherwise.
- `o_sel` and `o_gnt` always change on the same edge and are consistent: `o_gnt == 1 << o_sel` when busy.
- When IDLE, `o_sel` keeps its previous value.

## Timing
- Reset values:
  - `o_gnt = 0`, `o_busy = 0`, `o_sel = 0`.
  - `last = 3`, so requester 0 wins the first arbitration.
  - Counter = 0, state IDLE.
  - `o_data` shows `i_data0`.
- Grant latency: `i_req` sampled high at edge n gives `o_gnt` at edge n, visible in cycle n+1. The arbiter never grants combinationally.
- Release latency: `i_req[g]` sampled low at edge n gives a new grant or 0 from cycle n+1.
- Hold counter: counts edges on which g stays granted. With `MAX_HOLD = 8` and a competitor continuously pending, g owns the mux for exactly 8 cycles. The counter width is `$clog2(MAX_HOLD+1)`.
- Simultaneous release of g and a new request from g's successor: the successor is granted at the same edge.
- Reset asserted mid-grant: all outputs go to their reset values immediately, without waiting for a clock edge; pending requests are re-arbitrated from `last = 3` after reset is released.

## Structure
- Package `mux_arb_pkg`:
  - `N_REQ = 4`.
  - `SEL_W = 2`.
  - `typedef enum logic {IDLE, GRANT} arb_state_t`.
- Sub-module `rr_pick_4`, combinational:
  - Inputs: 4-bit request mask and `last`.
  - Outputs: `found` and a 2-bit index.
  - Used for both the normal and the preemption pick.
- Existing `mux_4 #(W)` instantiated once for `o_data`.

## Test plan
- Reset, then `i_req = 4'b0000` for 5 cycles: `o_gnt = 0`, `o_busy = 0`, `o_sel = 0`. Asserting `i_rst` mid-grant clears `o_gnt` immediately, before the next edge.
- `i_req = 4'b1111` held, `MAX_HOLD = 8`:
  - Grants rotate 0, 1, 2, 3, 0, each lasting exactly 8 cycles.
  - `o_data` follows `i_data0..3`, with inputs set to 4'h0, 4'h5, 4'hA, 4'hF.
- Only `i_req[2]` held for 20 cycles: `o_gnt = 4'b0100` throughout, with no preemption, since no competitor is pending.
- Requester 1 granted; drop `i_req[1]` on the same edge `i_req[3]` rises: `o_gnt = 4'b1000` in the next cycle, with no idle cycle.
- After requester 3 is served, `i_req = 4'b1001`: requester 0 is granted (search order 0, 1, 2, 3 from `last = 3`).
- `MAX_HOLD = 0`, `i_req = 4'b0011`: requester 0 keeps the grant until `i_req[0]` drops, then requester 1 is granted.
